// File: rtl/music_box_state_make_recording.sv
`default_nettype none
// ============================================================================
// Module      : music_box_state_make_recording
// Description : Captures a fixed number of audio sample slots into SDRAM
//               through a small sample buffer and a one-request write engine.
// Revision    : 1.0 - initial release
// ============================================================================
module music_box_state_make_recording #(
    parameter logic [4:0] RECORD_STATE   = 5'd2,
    parameter int         RECORD_SAMPLES = 110250,
    parameter int         FIFO_DEPTH     = 4,
    parameter int         ACK_TIMEOUT    = 4096
) (
    input  logic        clock_50Mhz,
    input  logic        reset,
    input  logic [4:0]  mainState,
    input  logic [15:0] sample_data,
    input  logic        sample_valid,
    output logic        stateComplete,
    output logic [31:0] debugString,
    output logic [24:0] sdram_inputAddress,
    output logic [15:0] sdram_writeData,
    output logic        sdram_isWriting,
    output logic        sdram_inputValid,
    input  logic        sdram_recievedCommand,
    input  logic        sdram_isBusy
);

    localparam logic [2:0]  c_S_IDLE    = 3'd0;
    localparam logic [2:0]  c_S_CAPTURE = 3'd1;
    localparam logic [2:0]  c_S_DRAIN   = 3'd2;
    localparam logic [2:0]  c_S_DONE    = 3'd3;
    localparam logic [2:0]  c_S_FAULT   = 3'd4;
    localparam logic [0:0]  c_ENG_IDLE  = 1'b0;
    localparam logic [0:0]  c_ENG_REQ   = 1'b1;

    localparam int          c_PTR_W        = $clog2(FIFO_DEPTH);
    localparam int          c_CNT_W        = $clog2(FIFO_DEPTH + 1);
    localparam int          c_TMR_W        = $clog2(ACK_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH        = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_TMR_W-1:0] c_TIMEOUT_LAST = c_TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [24:0]        c_SAMPLES      = 25'(RECORD_SAMPLES);

    logic [2:0]          r_state;
    logic [0:0]          r_eng;
    logic [24:0]         r_sample_index;
    logic [15:0]         r_overflow_count;
    logic [40:0]         r_fifo_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_TMR_W-1:0]  r_timer;

    logic        w_in_record;
    logic        w_eng_active;
    logic        w_pop;
    logic        w_strobe;
    logic        w_push;
    logic        w_drop;
    logic        w_issue;
    logic        w_timeout;
    logic [24:0] w_index_next;
    logic [40:0] w_head;

    assign w_in_record  = (mainState == RECORD_STATE);
    assign w_eng_active = (r_state == c_S_CAPTURE) || (r_state == c_S_DRAIN);
    assign w_pop        = w_eng_active && (r_eng == c_ENG_REQ) && sdram_recievedCommand;
    assign w_strobe     = (r_state == c_S_CAPTURE) && sample_valid;
    // A full buffer still accepts when the head leaves in the same cycle.
    assign w_push       = w_strobe && ((r_count < c_DEPTH) || w_pop);
    assign w_drop       = w_strobe && !w_push;
    assign w_issue      = w_eng_active && (r_eng == c_ENG_IDLE) && (r_count != '0) && !sdram_isBusy;
    assign w_timeout    = w_eng_active && (r_eng == c_ENG_REQ) && !sdram_recievedCommand
                          && (r_timer == c_TIMEOUT_LAST);
    assign w_index_next = r_sample_index + 25'd1;
    assign w_head       = r_fifo_mem[r_rd_ptr];

    assign stateComplete = (r_state == c_S_DONE);
    assign debugString   = {r_overflow_count, 13'd0, r_state};

    always_ff @(posedge clock_50Mhz) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= {r_sample_index, sample_data};
        end
    end

    always_ff @(posedge clock_50Mhz) begin
        // Leaving the record state aborts everything, exactly like reset.
        if (reset || !w_in_record) begin
            r_state            <= c_S_IDLE;
            r_eng              <= c_ENG_IDLE;
            r_sample_index     <= '0;
            r_overflow_count   <= '0;
            r_wr_ptr           <= '0;
            r_rd_ptr           <= '0;
            r_count            <= '0;
            r_timer            <= '0;
            sdram_inputAddress <= '0;
            sdram_writeData    <= '0;
            sdram_isWriting    <= 1'b0;
            sdram_inputValid   <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE:    r_state <= c_S_CAPTURE;
                c_S_CAPTURE: if (w_strobe && (w_index_next == c_SAMPLES)) r_state <= c_S_DRAIN;
                c_S_DRAIN:   if ((r_count == '0) && (r_eng == c_ENG_IDLE)) r_state <= c_S_DONE;
                c_S_DONE:    r_state <= c_S_DONE;
                c_S_FAULT:   r_state <= c_S_FAULT;
                default:     r_state <= c_S_IDLE;
            endcase
            if (w_timeout) begin
                r_state <= c_S_FAULT;
            end

            if (w_strobe) begin
                r_sample_index <= w_index_next;
            end
            if (w_drop && (r_overflow_count != 16'hFFFF)) begin
                r_overflow_count <= r_overflow_count + 16'd1;
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase

            if (w_issue) begin
                r_eng              <= c_ENG_REQ;
                r_timer            <= '0;
                sdram_inputAddress <= w_head[40:16];
                sdram_writeData    <= w_head[15:0];
                sdram_isWriting    <= 1'b1;
                sdram_inputValid   <= 1'b1;
            end else if (w_pop || w_timeout) begin
                r_eng              <= c_ENG_IDLE;
                sdram_isWriting    <= 1'b0;
                sdram_inputValid   <= 1'b0;
            end else if (w_eng_active && (r_eng == c_ENG_REQ)) begin
                r_timer <= r_timer + c_TMR_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_music_box_state_make_recording.sv
`default_nettype none
// ============================================================================
// Module      : tb_music_box_state_make_recording
// Description : Directed bench with a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_music_box_state_make_recording;

    localparam int RS    = 8;
    localparam int DEPTH = 4;
    localparam int TO    = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  mainState;
    logic [15:0] sample_data;
    logic        sample_valid;
    logic        sdram_recievedCommand;
    logic        sdram_isBusy;
    logic        stateComplete;
    logic [31:0] debugString;
    logic [24:0] sdram_inputAddress;
    logic [15:0] sdram_writeData;
    logic        sdram_isWriting;
    logic        sdram_inputValid;

    always #5 clk = ~clk;

    music_box_state_make_recording #(
        .RECORD_STATE  (5'd2),
        .RECORD_SAMPLES(RS),
        .FIFO_DEPTH    (DEPTH),
        .ACK_TIMEOUT   (TO)
    ) dut (
        .clock_50Mhz          (clk),
        .reset                (reset),
        .mainState            (mainState),
        .sample_data          (sample_data),
        .sample_valid         (sample_valid),
        .stateComplete        (stateComplete),
        .debugString          (debugString),
        .sdram_inputAddress   (sdram_inputAddress),
        .sdram_writeData      (sdram_writeData),
        .sdram_isWriting      (sdram_isWriting),
        .sdram_inputValid     (sdram_inputValid),
        .sdram_recievedCommand(sdram_recievedCommand),
        .sdram_isBusy         (sdram_isBusy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode 0..4, a queue for the buffer, one outstanding request.
    int          m_mode;
    logic [40:0] m_fifo [$];
    int          m_index;
    int          m_ovf;
    bit          m_req;
    logic [24:0] m_addr;
    logic [15:0] m_data;
    int          m_wait;

    logic [40:0] dut_writes [$];
    bit          auto_ack;

    task automatic model_step();
        bit          active, ack, timeout, issue, drain_done;
        logic [40:0] head;
        int          old_mode;
        if (reset || mainState != 5'd2) begin
            m_mode = 0; m_fifo.delete(); m_index = 0; m_ovf = 0;
            m_req = 0; m_addr = '0; m_data = '0; m_wait = 0;
            return;
        end
        old_mode   = m_mode;
        active     = (old_mode == 1) || (old_mode == 2);
        ack        = active && m_req && sdram_recievedCommand;
        timeout    = active && m_req && !sdram_recievedCommand && (m_wait + 1 == TO);
        issue      = active && !m_req && (m_fifo.size() != 0) && !sdram_isBusy;
        drain_done = (old_mode == 2) && (m_fifo.size() == 0) && !m_req;
        if (issue) begin
            head = m_fifo[0];
            m_addr = head[40:16]; m_data = head[15:0]; m_req = 1; m_wait = 0;
        end else if (ack || timeout) begin
            m_req = 0;
        end else if (m_req && active) begin
            m_wait++;
        end
        if (old_mode == 1 && sample_valid) begin
            if (m_fifo.size() < DEPTH || ack) m_fifo.push_back({m_index[24:0], sample_data});
            else if (m_ovf < 65535) m_ovf++;
            m_index++;
        end
        if (ack) void'(m_fifo.pop_front());
        if (old_mode == 0) m_mode = 1;
        else if (old_mode == 1 && sample_valid && m_index == RS) m_mode = 2;
        else if (drain_done) m_mode = 3;
        if (timeout) m_mode = 4;
    endtask

    task automatic check_outputs();
        logic [31:0] exp_dbg;
        bit          bad;
        exp_dbg = {m_ovf[15:0], 13'd0, m_mode[2:0]};
        bad = (stateComplete !== (m_mode == 3)) || (debugString !== exp_dbg)
              || (sdram_inputValid !== m_req) || (sdram_isWriting !== m_req);
        if (m_req || m_mode == 0)
            bad = bad || (sdram_inputAddress !== m_addr) || (sdram_writeData !== m_data);
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL cycle_compare t=%0t: got done=%b dbg=%h valid=%b wr=%b addr=%h data=%h; expected done=%b dbg=%h valid=%b addr=%h data=%h",
                     $time, stateComplete, debugString, sdram_inputValid, sdram_isWriting,
                     sdram_inputAddress, sdram_writeData, (m_mode == 3), exp_dbg, m_req, m_addr, m_data);
        end
    endtask

    task automatic step();
        if (sdram_recievedCommand && sdram_inputValid)
            dut_writes.push_back({sdram_inputAddress, sdram_writeData});
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        if (auto_ack) sdram_recievedCommand = sdram_inputValid;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic strobe(input logic [15:0] d);
        sample_data  = d;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_code(input logic [2:0] code, input int budget, input string name);
        int k = 0;
        while (debugString[2:0] !== code && k < budget) begin
            step();
            k++;
        end
        check_eq(name, 64'(debugString[2:0]), 64'(code));
    endtask

    initial begin
        int hi_cnt;
        logic [24:0] exp_addr [$];
        reset = 1'b1; mainState = 5'd0; sample_data = '0; sample_valid = 1'b0;
        sdram_recievedCommand = 1'b0; sdram_isBusy = 1'b0; auto_ack = 0;

        // Reset state
        idle(2);
        check_eq("reset_debug", 64'(debugString), 64'h0);
        check_eq("reset_complete", 64'(stateComplete), 64'h0);
        check_eq("reset_valid", 64'(sdram_inputValid), 64'h0);
        check_eq("reset_addr", 64'(sdram_inputAddress), 64'h0);
        reset = 1'b0;
        step();

        // Nominal recording with immediate acknowledges
        auto_ack = 1; mainState = 5'd2; dut_writes.delete();
        step();
        check_eq("enter_capture", 64'(debugString), 64'h0000_0001);
        for (int i = 0; i < RS; i++) begin
            strobe(16'h1000 + 16'(i));
            idle(2);
        end
        wait_code(3'd3, 60, "nominal_done_code");
        check_eq("nominal_nwrites", 64'(dut_writes.size()), 64'd8);
        for (int i = 0; i < dut_writes.size(); i++)
            check_eq($sformatf("nominal_write%0d", i), 64'(dut_writes[i]), {23'd0, 25'(i), 16'h1000 + 16'(i)});
        check_eq("nominal_debug", 64'(debugString), 64'h0000_0003);
        idle(3);
        check_eq("nominal_complete_held", 64'(stateComplete), 64'h1);

        // Reset while DONE
        reset = 1'b1;
        step();
        check_eq("rst_done_debug", 64'(debugString), 64'h0);
        check_eq("rst_done_complete", 64'(stateComplete), 64'h0);
        check_eq("rst_done_valid_wr", 64'({sdram_inputValid, sdram_isWriting}), 64'h0);
        check_eq("rst_done_addr_data", 64'({sdram_inputAddress, sdram_writeData}), 64'h0);
        reset = 1'b0; mainState = 5'd0;
        step();

        // Overflow while SDRAM busy
        mainState = 5'd2; sdram_isBusy = 1'b1; dut_writes.delete();
        step();
        for (int i = 0; i < 6; i++) begin
            strobe(16'h2000 + 16'(i));
            idle(1);
        end
        check_eq("ovf_debug", 64'(debugString), 64'h0002_0001);
        check_eq("ovf_no_valid", 64'(sdram_inputValid), 64'h0);
        sdram_isBusy = 1'b0;
        idle(20);
        check_eq("ovf_nwrites_a", 64'(dut_writes.size()), 64'd4);
        strobe(16'h2006); idle(2);
        strobe(16'h2007);
        wait_code(3'd3, 60, "ovf_done_code");
        exp_addr = '{25'd0, 25'd1, 25'd2, 25'd3, 25'd6, 25'd7};
        check_eq("ovf_nwrites", 64'(dut_writes.size()), 64'd6);
        for (int i = 0; i < dut_writes.size() && i < 6; i++)
            check_eq($sformatf("ovf_write%0d", i), 64'(dut_writes[i]),
                     {23'd0, exp_addr[i], 16'h2000 + 16'(exp_addr[i])});
        check_eq("ovf_final_debug", 64'(debugString), 64'h0002_0003);
        mainState = 5'd0;
        step();

        // Simultaneous push and pop with the buffer full
        mainState = 5'd2; auto_ack = 0; dut_writes.delete();
        step();
        for (int i = 0; i < 4; i++) strobe(16'h3000 + 16'(i));
        check_eq("full_req_valid", 64'(sdram_inputValid), 64'h1);
        sample_data = 16'h3004; sample_valid = 1'b1; sdram_recievedCommand = 1'b1;
        step();
        sample_valid = 1'b0; sdram_recievedCommand = 1'b0;
        check_eq("simul_no_overflow", 64'(debugString), 64'h0000_0001);
        auto_ack = 1;
        strobe(16'h3005);
        check_eq("full_after_simul_drops", 64'(debugString), 64'h0001_0001);
        idle(4);
        strobe(16'h3006); idle(4);
        strobe(16'h3007);
        wait_code(3'd3, 80, "simul_done_code");
        exp_addr = '{25'd0, 25'd1, 25'd2, 25'd3, 25'd4, 25'd6, 25'd7};
        check_eq("simul_nwrites", 64'(dut_writes.size()), 64'd7);
        for (int i = 0; i < dut_writes.size() && i < 7; i++)
            check_eq($sformatf("simul_write%0d", i), 64'(dut_writes[i]),
                     {23'd0, exp_addr[i], 16'h3000 + 16'(exp_addr[i])});
        check_eq("simul_final_debug", 64'(debugString), 64'h0001_0003);
        mainState = 5'd0;
        step();

        // Acknowledge timeout
        mainState = 5'd2; auto_ack = 0;
        step();
        strobe(16'h4000);
        hi_cnt = 0;
        for (int k = 0; k < 40 && debugString[2:0] !== 3'd4; k++) begin
            step();
            if (sdram_inputValid) hi_cnt++;
        end
        check_eq("timeout_valid_cycles", 64'(hi_cnt), 64'd16);
        check_eq("timeout_code", 64'(debugString[2:0]), 64'd4);
        strobe(16'h4001);
        idle(3);
        check_eq("fault_hold", 64'({stateComplete, sdram_inputValid, debugString[2:0]}), 64'h4);
        mainState = 5'd0;
        step();
        check_eq("fault_exit", 64'(debugString), 64'h0);

        // Abort while a request is outstanding, then restart
        mainState = 5'd2;
        step();
        strobe(16'h5000);
        strobe(16'h5001);
        check_eq("abort_pre_valid", 64'({sdram_inputValid, sdram_inputAddress}), {38'd0, 1'b1, 25'd0});
        mainState = 5'd0;
        step();
        check_eq("abort_valid", 64'(sdram_inputValid), 64'h0);
        check_eq("abort_idle", 64'(debugString), 64'h0);
        mainState = 5'd2; auto_ack = 1; dut_writes.delete();
        step();
        strobe(16'h5100);
        idle(4);
        check_eq("restart_nwrites", 64'(dut_writes.size()), 64'd1);
        if (dut_writes.size() > 0)
            check_eq("restart_write0", 64'(dut_writes[0]), {23'd0, 25'd0, 16'h5100});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
